cpu_cs_acal_seq: RTL and testbench

- Parametrised micro-address sequencer for the CPU control store.
- Registers the lower micro-address (LUA) and derives the upper micro-address (UUA) from a bank bit.
- Adds micro-PC increment, jump, and call/return through a micro-subroutine stack, with overflow and underflow flags.
- Sits between the control-store address bus (CSA) and the microprogram memories; the CSCA conditional-address source feeds the low UUA bank.

---
 rtl/cpu_cs_acal_seq.sv | 128 ++++++++++++
 tb/tb_cpu_cs_acal_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cpu_cs_acal_seq.sv
// Control-store micro-address sequencer: LUA register, banked UUA, micro-call stack.
// Ports: CLK/RESET_n; MACLK, OP, CSA, CSCA, CSCA_EN, PD1, ERR_CLR in; LUA, UUA, SP, FULL, EMPTY, OVF, UNF out.
module cpu_cs_acal_seq #(
  parameter int AW    = 13,
  parameter int CW    = 10,
  parameter int DEPTH = 4,
  parameter int SPW   = 3
) (
  input  logic          CLK,
  input  logic          RESET_n,
  input  logic          MACLK,
  input  logic [2:0]    OP,
  input  logic [AW-1:0] CSA,
  input  logic [CW-1:0] CSCA,
  input  logic          CSCA_EN,
  input  logic          PD1,
  input  logic          ERR_CLR,
  output logic [AW-1:0] LUA,
  output logic [AW-2:0] UUA,
  output logic [SPW-1:0] SP,
  output logic          FULL,
  output logic          EMPTY,
  output logic          OVF,
  output logic          UNF
);

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);
  localparam int NSLOT = 2 ** SPW;
  localparam int FW    = AW - 1 - CW;

  logic [AW-1:0]  lua_q, lua_d;
  logic [CW-1:0]  csca_q, csca_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [AW-1:0]  stack_q [NSLOT];

  logic [AW-1:0]  lua_inc;
  logic [SPW-1:0] sp_m1;
  logic           push;
  logic           ovf_set;
  logic           unf_set;
  logic [AW-2:0]  uua_lo;
  logic [AW-2:0]  uua_raw;

  assign lua_inc = lua_q + AW'(1);
  assign sp_m1   = sp_q - SPW'(1);

  always_comb begin
    lua_d   = lua_q;
    sp_d    = sp_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (MACLK) begin
      case (OP)
        OP_NEXT: lua_d = lua_inc;
        OP_JUMP: lua_d = CSA;
        OP_CALL: begin
          // Target is taken even when the push overflows.
          lua_d = CSA;
          if (sp_q < SP_MAX) begin
            push = 1'b1;
            sp_d = sp_q + SPW'(1);
          end else begin
            ovf_set = 1'b1;
          end
        end
        OP_RET: begin
          if (sp_q != '0) begin
            lua_d = stack_q[sp_m1];
            sp_d  = sp_m1;
          end else begin
            lua_d   = '0;
            unf_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign csca_d = CSCA_EN ? CSCA : csca_q;
  // A new error beats a clear on the same edge.
  assign ovf_d  = ovf_set | (ovf_q & ~ERR_CLR);
  assign unf_d  = unf_set | (unf_q & ~ERR_CLR);

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      lua_q  <= '0;
      csca_q <= '0;
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      for (int i = 0; i < NSLOT; i++) stack_q[i] <= '0;
    end else begin
      lua_q  <= lua_d;
      csca_q <= csca_d;
      sp_q   <= sp_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      if (push) stack_q[sp_q] <= lua_inc;
    end
  end

  generate
    if (FW > 0) begin : g_fill
      assign uua_lo = {{FW{1'b1}}, csca_q};
    end else begin : g_nofill
      assign uua_lo = csca_q;
    end
  endgenerate

  assign uua_raw = lua_q[AW-1] ? lua_q[AW-2:0] : uua_lo;

  assign LUA   = PD1 ? '0 : lua_q;
  assign UUA   = PD1 ? '0 : uua_raw;
  assign SP    = sp_q;
  assign FULL  = (sp_q == SP_MAX);
  assign EMPTY = (sp_q == '0);
  assign OVF   = ovf_q;
  assign UNF   = unf_q;

endmodule

// File: tb/tb_cpu_cs_acal_seq.sv
// Directed bench for cpu_cs_acal_seq.
// Drives op sequences and checks LUA/UUA/SP/flags with immediate assertions.
module tb_cpu_cs_acal_seq;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        MACLK;
  logic [2:0]  OP;
  logic [12:0] CSA;
  logic [9:0]  CSCA;
  logic        CSCA_EN;
  logic        PD1;
  logic        ERR_CLR;
  logic [12:0] LUA;
  logic [11:0] UUA;
  logic [2:0]  SP;
  logic        FULL, EMPTY, OVF, UNF;

  int n_cmp = 0;
  int n_err = 0;

  cpu_cs_acal_seq dut (
    .CLK(CLK), .RESET_n(RESET_n), .MACLK(MACLK), .OP(OP),
    .CSA(CSA), .CSCA(CSCA), .CSCA_EN(CSCA_EN), .PD1(PD1),
    .ERR_CLR(ERR_CLR), .LUA(LUA), .UUA(UUA), .SP(SP),
    .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF), .UNF(UNF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET_n = 1'b0; MACLK = 1'b1; OP = 3'd0; CSA = '0;
    CSCA = '0; CSCA_EN = 1'b0; PD1 = 1'b0; ERR_CLR = 1'b0;
    step(); step();
    chk("rst_lua", LUA, 0);
    chk("rst_uua", UUA, 12'hC00);
    chk("rst_sp", SP, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_flags", {OVF, UNF}, 0);

    @(negedge CLK); RESET_n = 1'b1;
    step();
    chk("first_next", LUA, 1);

    OP = 3'd1; CSA = 13'h1FFF; step();
    chk("jmp_lua", LUA, 13'h1FFF);
    chk("jmp_uua", UUA, 12'hFFF);
    OP = 3'd0; step();
    chk("wrap_lua", LUA, 0);
    chk("wrap_uua", UUA, 12'hC00);

    OP = 3'd1; CSA = 13'h0010; step();
    OP = 3'd2; CSA = 13'h0100; step();
    CSA = 13'h0200; step();
    CSA = 13'h0300; step();
    CSA = 13'h0400; step();
    chk("call4_lua", LUA, 13'h0400);
    chk("call4_sp", SP, 4);
    chk("call4_full", FULL, 1);
    chk("call4_ovf", OVF, 0);
    CSA = 13'h0500; step();
    chk("ovf_lua", LUA, 13'h0500);
    chk("ovf_flag", OVF, 1);
    chk("ovf_sp", SP, 4);

    OP = 3'd3; step();
    chk("ret1", LUA, 13'h0301);
    chk("ret1_sp", SP, 3);
    step();
    chk("ret2", LUA, 13'h0201);
    step();
    chk("ret3", LUA, 13'h0101);
    step();
    chk("ret4", LUA, 13'h0011);
    chk("ret4_empty", EMPTY, 1);
    chk("ovf_sticky", OVF, 1);

    ERR_CLR = 1'b1; step();
    chk("unf_lua", LUA, 0);
    chk("unf_set_wins", UNF, 1);
    chk("ovf_cleared", OVF, 0);
    chk("unf_sp", SP, 0);
    OP = 3'd4; step();
    chk("unf_clr", UNF, 0);
    ERR_CLR = 1'b0;

    MACLK = 1'b0; OP = 3'd0; CSCA = 10'h2A5; CSCA_EN = 1'b1; step();
    chk("maclk0_lua", LUA, 0);
    chk("csca_uua", UUA, 12'hEA5);
    CSCA_EN = 1'b0; CSCA = 10'h000;

    MACLK = 1'b1; OP = 3'd1; CSA = 13'h1234; step();
    chk("bank1_uua", UUA, 12'h234);
    chk("bank1_lua", LUA, 13'h1234);
    OP = 3'd6; step();
    chk("op6_hold", LUA, 13'h1234);

    OP = 3'd2; CSA = 13'h0ABC; step();
    chk("call_sp1", SP, 1);
    OP = 3'd4; PD1 = 1'b1; #1;
    chk("pd1_lua", LUA, 0);
    chk("pd1_uua", UUA, 0);
    chk("pd1_sp", SP, 1);
    step();
    PD1 = 1'b0; #1;
    chk("pd0_lua", LUA, 13'h0ABC);
    chk("pd0_uua", UUA, 12'hEA5);

    OP = 3'd2; CSA = 13'h1F00; step();
    chk("call_sp2", SP, 2);
    OP = 3'd0;
    #2 RESET_n = 1'b0;
    #1;
    chk("arst_sp", SP, 0);
    chk("arst_lua", LUA, 0);
    chk("arst_empty", EMPTY, 1);
    chk("arst_uua", UUA, 12'hC00);
    @(negedge CLK); RESET_n = 1'b1;
    OP = 3'd3; step();
    chk("post_rst_ret", LUA, 0);
    chk("post_rst_unf", UNF, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
